// File: rtl/adder_mp_seq.sv
// adder_mp_seq: sequential multi-precision, multi-lane adder.
// Operands are added one CHUNK_WIDTH slice per cycle through a single
// lookahead chunk adder. A registered carry links consecutive chunks of a lane.
// iMode splits the word into 1/2/4/8 lanes, and the carry is broken at lane edges.
// Optional feature macro: ADDER_MP_SUB_EN adds the iSub port (lane-wise A-B).
//
// state | meaning
// IDLE  | waiting for operands, oReady=1
// RUN   | adding chunk cnt this cycle
// DONE  | result held, oValid=1 until iReady
module adder_mp_seq #(
  parameter int DATA_WIDTH  = 256,
  parameter int CHUNK_WIDTH = 32
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [DATA_WIDTH-1:0] iA,
  input  logic [DATA_WIDTH-1:0] iB,
  input  logic                  iC,
  input  logic [1:0]            iMode,
`ifdef ADDER_MP_SUB_EN
  input  logic                  iSub,
`endif
  output logic                  oValid,
  input  logic                  iReady,
  output logic [DATA_WIDTH-1:0] oSum,
  output logic [7:0]            oC
);

  localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W  = $clog2(NCHUNK);
  localparam int LOG_CW = $clog2(CHUNK_WIDTH);
  localparam int NS     = CHUNK_WIDTH / 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0]  a_q, b_q, sum_q;
  logic                   cin_q;
  logic [1:0]             mode_q;
  logic [CNT_W-1:0]       cnt;
  logic                   carry_q;
  logic [7:0]             oc_q;
`ifdef ADDER_MP_SUB_EN
  logic                   sub_q;
`endif

  logic [CNT_W+LOG_CW-1:0] base;
  logic [CNT_W-1:0]        lane_mask;
  logic                    lane_first, lane_last;
  logic [2:0]              lane_idx;
  logic                    lane_cin;
  logic [CHUNK_WIDTH-1:0]  a_chunk, b_chunk;
  logic                    chunk_cin;
  logic [CHUNK_WIDTH-1:0]  chunk_sum;
  logic                    chunk_cout;

  // Chunk lookahead internals.
  logic [CHUNK_WIDTH-1:0] g, p, bc;
  logic [NS-1:0]          sg, sp;
  logic [NS:0]            sc;
  logic                   tp;

  assign base = {cnt, {LOG_CW{1'b0}}};

  // Lane geometry: chunks per lane is NCHUNK>>mode, so (NCHUNK-1)>>mode masks the
  // position of a chunk inside its lane.
  always_comb begin
    lane_mask  = LAST_CNT >> mode_q;
    lane_first = (cnt & lane_mask) == '0;
    lane_last  = (cnt & lane_mask) == lane_mask;
    lane_idx   = 3'd0;
    case (mode_q)
      2'd1:    lane_idx = {2'b00, cnt[CNT_W-1]};
      2'd2:    lane_idx = {1'b0, cnt[CNT_W-1 -: 2]};
      2'd3:    lane_idx = cnt[CNT_W-1 -: 3];
      default: lane_idx = 3'd0;
    endcase
  end

  // Operand slice selection and carry-in mux.
  always_comb begin
    a_chunk = a_q[base +: CHUNK_WIDTH];
`ifdef ADDER_MP_SUB_EN
    b_chunk  = b_q[base +: CHUNK_WIDTH] ^ {CHUNK_WIDTH{sub_q}};
    lane_cin = sub_q | cin_q;
`else
    b_chunk  = b_q[base +: CHUNK_WIDTH];
    lane_cin = cin_q;
`endif
    chunk_cin = lane_first ? lane_cin : carry_q;
  end

  // Lookahead chunk adder. It computes 4-bit slice group generate/propagate,
  // then expands every slice carry and every bit carry as a sum of products,
  // so no carry ripples between slices.
  always_comb begin
    g  = a_chunk & b_chunk;
    p  = a_chunk ^ b_chunk;
    sg = '0;
    sp = '0;
    sc = '0;
    bc = '0;
    tp = 1'b0;
    for (int s = 0; s < NS; s++) begin
      sp[s] = &p[4*s +: 4];
      sg[s] = g[4*s+3]
            | (p[4*s+3] & g[4*s+2])
            | (p[4*s+3] & p[4*s+2] & g[4*s+1])
            | (p[4*s+3] & p[4*s+2] & p[4*s+1] & g[4*s]);
    end
    for (int s = 0; s <= NS; s++) begin
      tp = 1'b1;
      for (int t = s - 1; t >= 0; t--) begin
        sc[s] = sc[s] | (sg[t] & tp);
        tp    = tp & sp[t];
      end
      sc[s] = sc[s] | (chunk_cin & tp);
    end
    for (int s = 0; s < NS; s++) begin
      for (int i = 0; i < 4; i++) begin
        tp = 1'b1;
        for (int t = i - 1; t >= 0; t--) begin
          bc[4*s+i] = bc[4*s+i] | (g[4*s+t] & tp);
          tp        = tp & p[4*s+t];
        end
        bc[4*s+i] = bc[4*s+i] | (sc[s] & tp);
      end
    end
  end

  assign chunk_sum  = p ^ bc;
  assign chunk_cout = sc[NS];

  // FSM state register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iValid) state_nxt = RUN;
      RUN:     if (cnt == LAST_CNT) state_nxt = DONE;
      DONE:    if (iReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    oReady = 1'b0;
    oValid = 1'b0;
    case (state)
      IDLE:    oReady = 1'b1;
      DONE:    oValid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch operands on accept, then write one chunk per RUN cycle.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      mode_q  <= 2'd0;
      cnt     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      oc_q    <= 8'h00;
`ifdef ADDER_MP_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (iValid) begin
          a_q    <= iA;
          b_q    <= iB;
          cin_q  <= iC;
          mode_q <= iMode;
          cnt    <= '0;
          sum_q  <= '0;
          oc_q   <= 8'h00;
`ifdef ADDER_MP_SUB_EN
          sub_q  <= iSub;
`endif
        end
        RUN: begin
          sum_q[base +: CHUNK_WIDTH] <= chunk_sum;
          carry_q <= chunk_cout;
          if (lane_last) oc_q[lane_idx] <= chunk_cout;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign oSum = sum_q;
  assign oC   = oc_q;

endmodule

// File: tb/tb_adder_mp_seq.sv
// Directed bench for adder_mp_seq with hand-computed expected results.
module tb_adder_mp_seq;

  logic         iClk = 1'b0;
  logic         iRst;
  logic         iValid;
  logic         oReady;
  logic [255:0] iA, iB;
  logic         iC;
  logic [1:0]   iMode;
  logic         iSub;
  logic         oValid;
  logic         iReady;
  logic [255:0] oSum;
  logic [7:0]   oC;

  int n_tests = 0;
  int n_fail  = 0;

  adder_mp_seq #(.DATA_WIDTH(256), .CHUNK_WIDTH(32)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iValid (iValid),
    .oReady (oReady),
    .iA     (iA),
    .iB     (iB),
    .iC     (iC),
    .iMode  (iMode),
`ifdef ADDER_MP_SUB_EN
    .iSub   (iSub),
`endif
    .oValid (oValid),
    .iReady (iReady),
    .oSum   (oSum),
    .oC     (oC)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [255:0] a, input logic [255:0] b,
                        input logic c, input logic [1:0] m, input logic s,
                        input logic [255:0] esum, input logic [7:0] eoc, input bit hold);
    int n;
    n = 0;
    while (!oReady && n < 20) begin
      @(posedge iClk); #1;
      n++;
    end
    chk({name, " ready"}, 256'(oReady), 256'd1);
    @(negedge iClk);
    iA = a; iB = b; iC = c; iMode = m; iSub = s; iValid = 1'b1;
    @(posedge iClk); #1;
    // Disturb the inputs: the block must use only the latched values.
    iValid = 1'b0; iA = '0; iB = '1; iC = ~c; iMode = ~m; iSub = ~s;
    n = 0;
    while (!oValid && n < 20) begin
      @(posedge iClk); #1;
      n++;
    end
    chk({name, " latency"}, 256'(n), 256'd8);
    chk({name, " sum"}, oSum, esum);
    chk({name, " carry"}, 256'(oC), 256'(eoc));
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge iClk);
        iValid = (i == 2);
        @(posedge iClk); #1;
        chk({name, " bp valid"}, 256'(oValid), 256'd1);
        chk({name, " bp ready"}, 256'(oReady), 256'd0);
        chk({name, " bp sum"}, oSum, esum);
        chk({name, " bp carry"}, 256'(oC), 256'(eoc));
      end
      @(negedge iClk);
      iValid = 1'b0;
    end
    @(negedge iClk);
    iReady = 1'b1;
    @(posedge iClk); #1;
    chk({name, " ready after ack"}, 256'(oReady), 256'd1);
    chk({name, " valid after ack"}, 256'(oValid), 256'd0);
    @(negedge iClk);
    iReady = 1'b0;
  endtask

  initial begin
    int vcnt;
    iRst = 1'b1; iValid = 1'b0; iReady = 1'b0;
    iA = '0; iB = '0; iC = 1'b0; iMode = 2'd0; iSub = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    chk("reset ready", 256'(oReady), 256'd1);
    chk("reset valid", 256'(oValid), 256'd0);
    chk("reset sum", oSum, 256'd0);
    chk("reset carry", 256'(oC), 256'd0);
    @(negedge iClk);
    iRst = 1'b0;

    run_op("m0_full", {256{1'b1}}, 256'd1, 1'b0, 2'd0, 1'b0, 256'd0, 8'h01, 1'b0);
    run_op("m3_lanes", {8{32'hFFFF_FFFF}}, {8{32'h1}}, 1'b0, 2'd3, 1'b0, 256'd0, 8'hFF, 1'b0);
    run_op("m1_cin", {128'h0, {128{1'b1}}}, {128'h0, 128'h1}, 1'b1, 2'd1, 1'b0,
           {128'h1, 128'h1}, 8'h01, 1'b0);
    run_op("m2_small", {4{64'd100}}, {4{64'd23}}, 1'b0, 2'd2, 1'b0, {4{64'd123}}, 8'h00, 1'b0);
    run_op("bp", 256'd5, 256'd7, 1'b1, 2'd0, 1'b0, 256'd13, 8'h00, 1'b1);

    // Reset while chunk 3 is being added.
    @(negedge iClk);
    iA = {256{1'b1}}; iB = 256'd1; iC = 1'b0; iMode = 2'd0; iValid = 1'b1;
    @(posedge iClk); #1;
    iValid = 1'b0;
    repeat (3) @(posedge iClk);
    #2;
    iRst = 1'b1;
    #1;
    chk("rst ready", 256'(oReady), 256'd1);
    chk("rst valid", 256'(oValid), 256'd0);
    @(negedge iClk);
    iRst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge iClk); #1;
      if (oValid) vcnt++;
    end
    chk("rst no valid", 256'(vcnt), 256'd0);
    chk("rst ready idle", 256'(oReady), 256'd1);
    run_op("m2_msb", {4{64'h8000_0000_0000_0000}}, {4{64'h8000_0000_0000_0000}}, 1'b0, 2'd2,
           1'b0, 256'd0, 8'h0F, 1'b0);

`ifdef ADDER_MP_SUB_EN
    run_op("sub_borrow", 256'd0, {4{64'd1}}, 1'b0, 2'd2, 1'b1,
           {4{64'hFFFF_FFFF_FFFF_FFFF}}, 8'h00, 1'b0);
    run_op("sub_equal", {4{64'd5}}, {4{64'd5}}, 1'b0, 2'd2, 1'b1, 256'd0, 8'h0F, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
